// File: rtl/mult_acc_round_sat_if.sv
// Valid/ready bundle between the product source, the frame accumulator and the result consumer.
interface mult_acc_round_sat_if #(
  parameter int IN_W  = 46,
  parameter int OUT_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mult_acc_round_sat.sv
// Accumulates ACC_LEN signed products per frame, then rounds (half up) and saturates
// the sum into a held valid/ready result register.
module mult_acc_round_sat #(
  parameter int IN_W    = 46,
  parameter int ACC_LEN = 64,
  parameter int ACC_W   = 52,
  parameter int SHIFT   = 22,
  parameter int OUT_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  mult_acc_round_sat_if.slave  bus
);
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_W:0]   HALF    = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0]   SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0]   SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  if (ACC_W < IN_W + $clog2(ACC_LEN)) begin : g_bad_acc_w
    $error("mult_acc_round_sat: ACC_W too small for IN_W and ACC_LEN");
  end

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_dump_pend;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_dump;
  logic signed [ACC_W-1:0] w_in_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [OUT_W-1:0] w_res;
  logic                    w_sat;

  assign bus.in_ready  = !r_dump_pend;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  // clr wins over a coincident sample, so the sample is never accepted.
  assign w_accept   = bus.in_valid && !r_dump_pend && !clr;
  assign w_last     = (r_cnt == LAST);
  assign w_dump     = r_dump_pend && (!r_out_valid || bus.out_ready);
  assign w_in_ext   = {{(ACC_W - IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
  assign w_acc_next = (r_cnt == '0) ? w_in_ext : (r_acc + w_in_ext);

  assign w_sum = {r_acc[ACC_W-1], r_acc} + HALF;
  assign w_rnd = w_sum >>> SHIFT;

  always_comb begin
    w_res = w_rnd[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_rnd > SAT_MAX) begin
      w_res = SAT_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_rnd < SAT_MIN) begin
      w_res = SAT_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dump_pend <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_next;
      end
      if (clr) begin
        r_cnt       <= '0;
        r_dump_pend <= 1'b0;
      end else begin
        if (w_accept) begin
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        if (w_accept && w_last) begin
          r_dump_pend <= 1'b1;
        end else if (w_dump) begin
          r_dump_pend <= 1'b0;
        end
      end
      // A dump completes even under clr: the output register is already being loaded.
      if (w_dump) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_sat   <= w_sat;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_acc_round_sat.sv
// Directed bench: default-parameter instance plus a small ACC_LEN=4/SHIFT=2/OUT_W=8 instance.
module tb_mult_acc_round_sat;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_b = 1'b0;
  logic clr_s = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_acc_round_sat_if #(.IN_W(46), .OUT_W(24)) bb ();
  mult_acc_round_sat_if #(.IN_W(16), .OUT_W(8))  bs ();

  mult_acc_round_sat u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_b),
    .bus   (bb.slave)
  );

  mult_acc_round_sat #(
    .IN_W(16), .ACC_LEN(4), .ACC_W(18), .SHIFT(2), .OUT_W(8)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .bus   (bs.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_s(input int v);
    logic rdy;
    int   n;
    n = 0;
    bs.in_valid = 1'b1;
    bs.in_data  = 16'(v);
    do begin
      rdy = bs.in_ready;
      step();
      n++;
    end while (!rdy && n < 20);
    chk("push_accept", rdy, 1'b1);
  endtask

  task automatic frame_s(input string tag, input int a, input int b, input int c, input int d,
                         input int exp, input logic exp_sat);
    int n;
    push_s(a);
    push_s(b);
    push_s(c);
    push_s(d);
    bs.in_valid = 1'b0;
    n = 0;
    while (!bs.out_valid && n < 5) begin
      step();
      n++;
    end
    $display("frame %s: out_data=%0d out_sat=%0b", tag, bs.out_data, bs.out_sat);
    chk({tag, "_valid"}, bs.out_valid, 1'b1);
    chk({tag, "_data"}, bs.out_data, exp);
    chk({tag, "_sat"}, bs.out_sat, exp_sat);
  endtask

  initial begin
    bb.in_valid = 1'b0; bb.in_data = '0; bb.out_ready = 1'b1;
    bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b1;
    repeat (2) step();
    chk("rst_big_valid", bb.out_valid, 1'b0);
    chk("rst_big_data", bb.out_data, 0);
    chk("rst_big_sat", bb.out_sat, 1'b0);
    chk("rst_big_ready", bb.in_ready, 1'b1);
    chk("rst_small_valid", bs.out_valid, 1'b0);
    chk("rst_small_ready", bs.in_ready, 1'b1);
    #2 rst_n = 1'b1;
    step();

    // 64 samples of 2^22 -> 2^28 -> 64.
    for (int i = 0; i < 64; i++) begin
      bb.in_valid = 1'b1;
      bb.in_data  = 46'sd4194304;
      chk("big_ready_during_frame", bb.in_ready, 1'b1);
      step();
    end
    bb.in_valid = 1'b0;
    chk("big_bubble_ready", bb.in_ready, 1'b0);
    chk("big_valid_not_yet", bb.out_valid, 1'b0);
    step();
    $display("big frame: out_data=%0d out_sat=%0b", bb.out_data, bb.out_sat);
    chk("big_valid", bb.out_valid, 1'b1);
    chk("big_data", bb.out_data, 64);
    chk("big_sat", bb.out_sat, 1'b0);
    chk("big_ready_back", bb.in_ready, 1'b1);
    step();
    chk("big_valid_drop", bb.out_valid, 1'b0);

    frame_s("rnd_1100", 1, 1, 0, 0, 1, 1'b0);
    frame_s("rnd_1000", 1, 0, 0, 0, 0, 1'b0);
    frame_s("rnd_m1m1", -1, -1, 0, 0, 0, 1'b0);
    frame_s("rnd_m3", -3, 0, 0, 0, -1, 1'b0);
    frame_s("sat_pos", 200, 200, 200, 200, 127, 1'b1);
    frame_s("sat_neg", -200, -200, -200, -200, -128, 1'b1);
    frame_s("sat_edge", 127, 127, 127, 127, 127, 1'b0);
    step();

    // Backpressure: frame {4..} -> 4 held, frame {8..} -> 8 pending behind it.
    bs.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_s(4);
    for (int i = 0; i < 4; i++) push_s(8);
    bs.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", bs.in_ready, 1'b0);
      chk("bp_valid_held", bs.out_valid, 1'b1);
      chk("bp_data_stable", bs.out_data, 4);
      step();
    end
    bs.out_ready = 1'b1;
    step();
    $display("bp second result: out_valid=%0b out_data=%0d", bs.out_valid, bs.out_data);
    chk("bp_second_valid", bs.out_valid, 1'b1);
    chk("bp_second_data", bs.out_data, 8);
    step();
    chk("bp_drain", bs.out_valid, 1'b0);

    // clr: partial frame of 100s discarded; sample coincident with clr dropped.
    push_s(100);
    push_s(100);
    clr_s = 1'b1;
    bs.in_valid = 1'b1;
    bs.in_data  = 16'sd50;
    step();
    clr_s = 1'b0;
    frame_s("clr", 4, 4, 4, 4, 4, 1'b0);
    step();

    // Async reset with a held saturated result and a partial frame in flight.
    bs.out_ready = 1'b0;
    frame_s("pre_reset", 200, 200, 200, 200, 127, 1'b1);
    push_s(100);
    push_s(100);
    bs.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: out_valid=%0b out_data=%0d out_sat=%0b", bs.out_valid, bs.out_data, bs.out_sat);
    chk("arst_valid", bs.out_valid, 1'b0);
    chk("arst_data", bs.out_data, 0);
    chk("arst_sat", bs.out_sat, 1'b0);
    chk("arst_ready", bs.in_ready, 1'b1);
    #2 rst_n = 1'b1;
    bs.out_ready = 1'b1;
    step();
    frame_s("post_reset", 1, 1, 0, 0, 1, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
